// File: rtl/fht_addr_gen_pkg.sv
// ----------------------------------------------------------------------------
// fht_addr_gen_pkg
//   Shared definitions for the FHT address sequencer: FSM state encoding and
//   the default geometry (log2 of transform size, read-to-write latency).
//   Optional feature macro used by the top level: FHT_STALL_EN.
// ----------------------------------------------------------------------------
package fht_addr_gen_pkg;

   // Default log2(N): N = 2**FHT_A_BIT_DEF points, FHT_A_BIT_DEF stages.
   localparam int FHT_A_BIT_DEF  = 8;
   // Read issue to write-back latency: 1 (sync RAM read) + 2 (butterfly).
   localparam int FHT_WR_DLY_DEF = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } fht_state_t;

endpackage

// File: rtl/fht_dly_line.sv
// ----------------------------------------------------------------------------
// fht_dly_line
//   Fixed-depth shift register with asynchronous active-high reset. Used to
//   carry {rd_en, X0, X1} forward so the write strobe and write addresses
//   line up with the butterfly result.
// Ports:
//   clk   in   1      clock, rising edge
//   rst   in   1      asynchronous active-high reset, clears every stage
//   din   in   WIDTH  value entering the line
//   dout  out  WIDTH  value from DEPTH cycles earlier
// ----------------------------------------------------------------------------
module fht_dly_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stg
         logic [WIDTH-1:0] stg_d;
         logic [WIDTH-1:0] stg_q;

         if (gi == 0) begin : g_first
            always_comb stg_d = din;
         end else begin : g_rest
            always_comb stg_d = g_stg[gi-1].stg_q;
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) stg_q <= '0;
            else     stg_q <= stg_d;
         end
      end
   endgenerate

   assign dout = g_stg[DEPTH-1].stg_q;

endmodule

// File: rtl/fht_addr_gen.sv
// ----------------------------------------------------------------------------
// fht_addr_gen
//   Address sequencer for a radix-2 FHT butterfly. Walks all A_BIT stages,
//   issuing one butterfly per RUN cycle (three operand read addresses plus
//   the sin/cos ROM address), then after WR_DLY cycles the two write-back
//   addresses. Data lives in two ping-pong banks: stage s reads oBANK and
//   writes ~oBANK; the bank flips between stages, so no in-place hazards.
//
//   Optional feature macro: FHT_STALL_EN
//     defined   : adds input iSTALL. iSTALL high in a RUN cycle removes the
//                 issue slot of the following cycle (outputs stay fully
//                 registered); the issue index holds and the write delay line
//                 keeps shifting, so the bubble reaches oWR_EN WR_DLY later.
//     undefined : no iSTALL port, one issue every RUN cycle.
//
// Ports:
//   iCLK        in   1         clock, rising edge
//   iRESET      in   1         asynchronous active-high reset
//   iSTART      in   1         start a transform (sampled only in IDLE)
//   iSTALL      in   1         issue stall (only with FHT_STALL_EN)
//   oRDY        out  1         high while idle
//   oRD_EN      out  1         read strobe for X0/X1/X2 and ROM
//   oADDR_X0    out  A_BIT     operand X0 address
//   oADDR_X1    out  A_BIT     operand X1 address
//   oADDR_X2    out  A_BIT     operand X2 (mirror) address
//   oADDR_W     out  A_BIT-1   sin/cos ROM address
//   oBANK       out  1         read bank; write bank is ~oBANK
//   oWR_EN      out  1         write strobe for Y0/Y1
//   oWR_ADDR_0  out  A_BIT     Y0 write address
//   oWR_ADDR_1  out  A_BIT     Y1 write address
//   oSTAGE      out  clog2     current stage
//   oDONE       out  1         one-cycle completion pulse
// ----------------------------------------------------------------------------
module fht_addr_gen
   import fht_addr_gen_pkg::*;
#(
   parameter  int A_BIT  = FHT_A_BIT_DEF,
   parameter  int WR_DLY = FHT_WR_DLY_DEF,
   localparam int ST_W   = $clog2(A_BIT)
) (
   input  logic             iCLK,
   input  logic             iRESET,
   input  logic             iSTART,
`ifdef FHT_STALL_EN
   input  logic             iSTALL,
`endif
   output logic             oRDY,
   output logic             oRD_EN,
   output logic [A_BIT-1:0] oADDR_X0,
   output logic [A_BIT-1:0] oADDR_X1,
   output logic [A_BIT-1:0] oADDR_X2,
   output logic [A_BIT-2:0] oADDR_W,
   output logic             oBANK,
   output logic             oWR_EN,
   output logic [A_BIT-1:0] oWR_ADDR_0,
   output logic [A_BIT-1:0] oWR_ADDR_1,
   output logic [ST_W-1:0]  oSTAGE,
   output logic             oDONE
);

   localparam int CNT_W = (WR_DLY > 1) ? $clog2(WR_DLY) : 1;
   localparam int DL_W  = 1 + 2 * A_BIT;

   localparam logic [A_BIT-1:0] ONE_A      = {{(A_BIT-1){1'b0}}, 1'b1};
   // Issue counter reaches N/2 once the last butterfly of a stage is out.
   localparam logic [A_BIT-1:0] N_HALF     = {1'b1, {(A_BIT-1){1'b0}}};
   localparam logic [ST_W-1:0]  LAST_STAGE = ST_W'(A_BIT - 1);
   localparam logic [ST_W-1:0]  ST_ONE     = ST_W'(1);
   localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(WR_DLY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic stall_w;
`ifdef FHT_STALL_EN
   assign stall_w = iSTALL;
`else
   assign stall_w = 1'b0;
`endif

   fht_state_t       state_q, state_d;
   logic [ST_W-1:0]  stage_q, stage_d;
   logic [A_BIT-1:0] n_q, n_d;          // issues made so far in this stage
   logic [CNT_W-1:0] cnt_q, cnt_d;      // DRAIN cycle counter
   logic             bank_q, bank_d;
   logic             issue;             // an issue is registered at this edge

   logic             rd_en_q, rd_en_d;
   logic [A_BIT-1:0] x0_q, x0_d;
   logic [A_BIT-1:0] x1_q, x1_d;
   logic [A_BIT-1:0] x2_q, x2_d;
   logic [A_BIT-2:0] w_q, w_d;

   // ---------------------------------------------------------------- state
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         state_q <= ST_IDLE;
         stage_q <= '0;
         n_q     <= '0;
         cnt_q   <= '0;
         bank_q  <= 1'b0;
         rd_en_q <= 1'b0;
         x0_q    <= '0;
         x1_q    <= '0;
         x2_q    <= '0;
         w_q     <= '0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         bank_q  <= bank_d;
         rd_en_q <= rd_en_d;
         x0_q    <= x0_d;
         x1_q    <= x1_d;
         x2_q    <= x2_d;
         w_q     <= w_d;
      end
   end

   // ----------------------------------------------------------- next state
   // The first issue of every stage is registered on the edge that enters
   // RUN, so the outputs show issue j during the j-th RUN cycle and the last
   // write of a stage lands in its final DRAIN cycle.
   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      n_d     = n_q;
      cnt_d   = cnt_q;
      bank_d  = bank_q;
      issue   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (iSTART) begin
               state_d = ST_RUN;
               stage_d = '0;
               bank_d  = 1'b0;
               n_d     = ONE_A;
               issue   = 1'b1;
            end
         end
         ST_RUN: begin
            if (n_q == N_HALF) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
            end else if (!stall_w) begin
               n_d   = n_q + ONE_A;
               issue = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (cnt_q == LAST_CNT) begin
               if (stage_q == LAST_STAGE) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
                  stage_d = stage_q + ST_ONE;
                  bank_d  = ~bank_q;
                  n_d     = ONE_A;
                  issue   = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            stage_d = '0;
            bank_d  = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // --------------------------------------------------------------- output
   logic [A_BIT-2:0] j_iss;
   logic [A_BIT-1:0] j_a, h_a, m_a, k_a, base_a, x2k_a;
   logic [A_BIT-2:0] w_a;
   logic [ST_W-1:0]  w_sh;

   always_comb begin
      // Index of the butterfly being registered at this edge: 0 when a
      // stage is being entered, otherwise the running issue count.
      j_iss  = (state_q == ST_RUN) ? n_q[A_BIT-2:0] : '0;
      j_a    = {1'b0, j_iss};
      h_a    = ONE_A << stage_d;           // H = 2**s
      m_a    = h_a - ONE_A;                // mask for j mod H
      k_a    = j_a & m_a;
      base_a = (j_a & ~m_a) << 1;          // (j >> s) * 2H
      x2k_a  = (h_a - k_a) & m_a;          // (H - k) mod H, so k=0 gives X1
      w_sh   = LAST_STAGE - stage_d;
      w_a    = k_a[A_BIT-2:0] << w_sh;

      rd_en_d = issue;
      x0_d    = issue ? (base_a | k_a)         : '0;
      x1_d    = issue ? (base_a | h_a | k_a)   : '0;
      x2_d    = issue ? (base_a | h_a | x2k_a) : '0;
      w_d     = issue ? w_a                    : '0;

      oRDY  = (state_q == ST_IDLE);
      oDONE = (state_q == ST_DONE);
   end

   assign oRD_EN   = rd_en_q;
   assign oADDR_X0 = x0_q;
   assign oADDR_X1 = x1_q;
   assign oADDR_X2 = x2_q;
   assign oADDR_W  = w_q;
   assign oBANK    = bank_q;
   assign oSTAGE   = stage_q;

   // ------------------------------------------------------ write alignment
   logic [DL_W-1:0] dl_out;

   fht_dly_line #(
      .WIDTH (DL_W),
      .DEPTH (WR_DLY)
   ) u_dly (
      .clk  (iCLK),
      .rst  (iRESET),
      .din  ({rd_en_q, x0_q, x1_q}),
      .dout (dl_out)
   );

   assign oWR_EN     = dl_out[DL_W-1];
   assign oWR_ADDR_0 = dl_out[2*A_BIT-1:A_BIT];
   assign oWR_ADDR_1 = dl_out[A_BIT-1:0];

endmodule

// File: tb/tb_fht_addr_gen.sv
`timescale 1ns/1ps
module tb_fht_addr_gen;

   localparam int A_BIT  = 3;
   localparam int WR_DLY = 3;
   localparam int NH     = 4;
   localparam int MAXC   = 64;

   logic             iCLK = 1'b0;
   logic             iRESET = 1'b1;
   logic             iSTART = 1'b0;
`ifdef FHT_STALL_EN
   logic             iSTALL = 1'b0;
`endif
   logic             oRDY, oRD_EN, oBANK, oWR_EN, oDONE;
   logic [A_BIT-1:0] oADDR_X0, oADDR_X1, oADDR_X2, oWR_ADDR_0, oWR_ADDR_1;
   logic [A_BIT-2:0] oADDR_W;
   logic [1:0]       oSTAGE;

   fht_addr_gen #(.A_BIT(A_BIT), .WR_DLY(WR_DLY)) dut (
      .iCLK       (iCLK),
      .iRESET     (iRESET),
      .iSTART     (iSTART),
`ifdef FHT_STALL_EN
      .iSTALL     (iSTALL),
`endif
      .oRDY       (oRDY),
      .oRD_EN     (oRD_EN),
      .oADDR_X0   (oADDR_X0),
      .oADDR_X1   (oADDR_X1),
      .oADDR_X2   (oADDR_X2),
      .oADDR_W    (oADDR_W),
      .oBANK      (oBANK),
      .oWR_EN     (oWR_EN),
      .oWR_ADDR_0 (oWR_ADDR_0),
      .oWR_ADDR_1 (oWR_ADDR_1),
      .oSTAGE     (oSTAGE),
      .oDONE      (oDONE)
   );

   always #5 iCLK = ~iCLK;

   int checks = 0;
   int failures = 0;

   // Expected outputs per cycle offset from the accepted start edge.
   int t_rd[MAXC], t_x0[MAXC], t_x1[MAXC], t_x2[MAXC], t_w[MAXC];
   int t_stage[MAXC], t_bank[MAXC], t_wr[MAXC], t_wa0[MAXC], t_wa1[MAXC];
   int done_cyc = 0;
   int off = -1;        // offset of the current cycle, -1 when idle
   int gap_slot = -1;   // global issue slot delayed by a stall, -1 = none
   int gap_len = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Timeline straight from the transform definition: stages of N/2 issues
   // followed by WR_DLY drain cycles, writes WR_DLY after their reads.
   function automatic void build(input int gslot, input int glen);
      int t, slot, h, k, base;
      for (int c = 0; c < MAXC; c++) begin
         t_rd[c] = 0; t_x0[c] = 0; t_x1[c] = 0; t_x2[c] = 0; t_w[c] = 0;
         t_stage[c] = 0; t_bank[c] = 0; t_wr[c] = 0; t_wa0[c] = 0; t_wa1[c] = 0;
      end
      t = 1;
      slot = 0;
      for (int s = 0; s < A_BIT; s++) begin
         for (int j = 0; j < NH; j++) begin
            if (slot == gslot) t += glen;
            h = 2 ** s;
            k = j % h;
            base = (j / h) * 2 * h;
            t_rd[t] = 1;
            t_x0[t] = base + k;
            t_x1[t] = base + h + k;
            t_x2[t] = base + h + ((h - k) % h);
            t_w[t] = k * (2 ** (A_BIT - 1 - s));
            t_stage[t] = s;
            t_bank[t] = s % 2;
            t_wr[t + WR_DLY] = 1;
            t_wa0[t + WR_DLY] = base + k;
            t_wa1[t + WR_DLY] = base + h + k;
            t++;
            slot++;
         end
         t += WR_DLY;
      end
      done_cyc = t;
   endfunction

   // Single compare process, sampling on the falling edge.
   always @(negedge iCLK) begin
      if (iRESET) begin
         off = -1;
      end else begin
         if (off < 0) begin
            check("idle_rdy", oRDY, 1);
            check("idle_rd_en", oRD_EN, 0);
            check("idle_x0", oADDR_X0, 0);
            check("idle_wr_en", oWR_EN, 0);
            check("idle_done", oDONE, 0);
            check("idle_bank", oBANK, 0);
            check("idle_stage", oSTAGE, 0);
         end else begin
            check("rdy", oRDY, 0);
            check("rd_en", oRD_EN, t_rd[off]);
            check("x0", oADDR_X0, t_x0[off]);
            check("x1", oADDR_X1, t_x1[off]);
            check("x2", oADDR_X2, t_x2[off]);
            check("w", oADDR_W, t_w[off]);
            check("wr_en", oWR_EN, t_wr[off]);
            check("wr_addr0", oWR_ADDR_0, t_wa0[off]);
            check("wr_addr1", oWR_ADDR_1, t_wa1[off]);
            check("done", oDONE, (off == done_cyc) ? 1 : 0);
            if (t_rd[off] != 0) begin
               check("stage", oSTAGE, t_stage[off]);
               check("bank", oBANK, t_bank[off]);
            end
            if (off == done_cyc) check("done_bank", oBANK, (A_BIT % 2) ^ 1);
         end
         if (off >= 0) off = (off >= done_cyc) ? -1 : off + 1;
         else if (iSTART) begin
            build(gap_slot, gap_len);
            off = 1;
         end
      end
   end

   task automatic tick();
      @(posedge iCLK);
      #2;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (off != -1 && n < budget) begin
         tick();
         n++;
      end
      check("wait_idle_timeout", (off == -1) ? 1 : 0, 1);
   endtask

   // Start pulse held for 'hold' cycles, optional iSTART noise while busy.
   task automatic run_one(input int hold, input bit noise);
      int n = 0;
      iSTART = 1'b1;
      repeat (hold) tick();
      iSTART = 1'b0;
      while (off != -1 && n < 200) begin
         iSTART = (noise && $urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
         tick();
         n++;
      end
      iSTART = 1'b0;
      check("run_timeout", (off == -1) ? 1 : 0, 1);
   endtask

   initial begin
      int rs;
      // Pin the model against hand-derived values.
      build(-1, 0);
      $display("model pins: stage0/1/2 samples, done cycle");
      check("pin_s0j0_x1", t_x1[1], 1);
      check("pin_s0j1_x0", t_x0[2], 2);
      check("pin_s1j1_x1", t_x1[9], 3);
      check("pin_s1j1_x2", t_x2[9], 3);
      check("pin_s1j1_w", t_w[9], 2);
      check("pin_s1j2_x0", t_x0[10], 4);
      check("pin_s2j1_x2", t_x2[16], 7);
      check("pin_s2j1_w", t_w[16], 1);
      check("pin_s2j3_x2", t_x2[18], 5);
      check("pin_s2j3_w", t_w[18], 3);
      check("pin_done_cyc", done_cyc, 22);
      check("pin_drain_rd", t_rd[5], 0);
      check("pin_first_wr", t_wr[4], 1);

      // Reset state.
      repeat (3) tick();
      check("rst_rdy", oRDY, 1);
      check("rst_rd_en", oRD_EN, 0);
      check("rst_wr_en", oWR_EN, 0);
      iRESET = 1'b0;
      repeat (2) tick();

      $display("txn: single start pulse, full transform");
      run_one(1, 1'b0);
      repeat (2) tick();

      $display("txn: start held 3 cycles plus start noise during run");
      run_one(3, 1'b1);
      repeat (2) tick();

      $display("txn: reset mid stage 1");
      rs = 8 + $urandom_range(0, 3);
      iSTART = 1'b1;
      tick();
      iSTART = 1'b0;
      while (off != rs && off != -1) tick();
      iRESET = 1'b1;
      #1;
      check("arst_rd_en", oRD_EN, 0);
      check("arst_x0", oADDR_X0, 0);
      check("arst_x1", oADDR_X1, 0);
      check("arst_x2", oADDR_X2, 0);
      check("arst_wr_en", oWR_EN, 0);
      check("arst_wa1", oWR_ADDR_1, 0);
      check("arst_bank", oBANK, 0);
      check("arst_stage", oSTAGE, 0);
      check("arst_rdy", oRDY, 1);
      repeat (2) tick();
      iRESET = 1'b0;
      repeat (4) tick();

      $display("txn: restart after reset");
      run_one(1, 1'b0);

`ifdef FHT_STALL_EN
      $display("txn: two-cycle stall at stage 0 j=2");
      build(2, 2);
      check("pin_stall_done", done_cyc, 24);
      check("pin_stall_gap", t_rd[3], 0);
      check("pin_stall_j2", t_x0[5], 4);
      gap_slot = 2;
      gap_len = 2;
      iSTART = 1'b1;
      tick();
      iSTART = 1'b0;
      tick();
      iSTALL = 1'b1;
      repeat (2) tick();
      iSTALL = 1'b0;
      wait_idle(100);
      gap_slot = -1;
      gap_len = 0;
      repeat (2) tick();
`endif

      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, 5)) tick();
         $display("txn: random transform %0d", i);
         run_one($urandom_range(1, 3), 1'b1);
      end
      wait_idle(100);
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end

endmodule
